// File: rtl/data_main_memory.sv
// -----------------------------------------------------------------------------
// data_main_memory
//
// Block-granular main data memory. It answers the data cache's refill (read)
// and dirty-eviction (write) requests after a fixed, parameterised latency,
// using a busywait handshake.
//
// Ports:
//   clock      system clock; all state changes on the rising edge
//   reset      synchronous, active-high reset
//   read       block read request; the requester holds it until busywait falls
//   write      block write request; the requester holds it until busywait falls
//   address    28-bit block address; only address[IDX_W-1:0] selects a block
//   writedata  128-bit block to store on a write
//   readdata   128-bit registered block returned by a read
//   busywait   high while a request is pending; low means the op has completed
//
// Timing: a request accepted at edge k commits at edge k+LATENCY. The cycle
// after that edge is ACK, where busywait is low and readdata is valid. The
// next edge always returns to IDLE.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module data_main_memory #(
  parameter int LATENCY      = 4,
  parameter int DEPTH_BLOCKS = 256,
  parameter int IDX_W        = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         read,
  input  logic         write,
  input  logic [27:0]  address,
  input  logic [127:0] writedata,
  output logic [127:0] readdata,
  output logic         busywait
);

  // Wide enough to hold LATENCY-1; never narrower than one bit.
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               op_write_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [127:0]       wdata_reg;
  logic [127:0]       readdata_reg;

  logic [127:0]       mem [DEPTH_BLOCKS];

  logic               request;
  logic               commit;

  // Exactly one of read/write is a legal request; both high is ignored.
  assign request = read ^ write;
  assign commit  = (state_reg == ACCESS) && (cnt_reg == '0);

  // Upper address bits alias onto the same block and are intentionally unused.
  generate
    if (IDX_W < 28) begin : g_unused_addr
      logic unused_addr_bits;
      assign unused_addr_bits = ^address[27:IDX_W];
    end
  endgenerate

  // Control path and registered read port.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      readdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (request) begin
            // Capture everything now; later input changes are ignored.
            op_write_reg <= write;
            idx_reg      <= address[IDX_W-1:0];
            wdata_reg    <= writedata;
            cnt_reg      <= CNT_W'(LATENCY - 1);
            state_reg    <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end else begin
            if (!op_write_reg) begin
              readdata_reg <= mem[idx_reg];
            end
            state_reg <= ACK;
          end
        end
        ACK: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Storage write port. The array itself is never cleared. A reset that
  // coincides with the commit edge still drops the write.
  always_ff @(posedge clock) begin
    if (!reset && commit && op_write_reg) begin
      mem[idx_reg] <= wdata_reg;
    end
  end

  // busywait is combinational so that it rises in the request cycle itself.
  always_comb begin
    busywait = 1'b0;
    if (!reset) begin
      case (state_reg)
        IDLE:    busywait = request;
        ACCESS:  busywait = 1'b1;
        default: busywait = 1'b0;
      endcase
    end
  end

  assign readdata = readdata_reg;

endmodule
